data_mem: RTL
=============

// Module: data_mem
// PURPOSE
//  Word-organised data RAM on the CPU's MEM-stage port; consumes ram_addr/ram_data_in/ram_sel/ram_rw/ram_extend_type, returns ram_data_out.
//  Combinational, lane-aligned and extended read. Synchronous byte-lane write.
//  Optional post-reset clear sweep holds the CPU off through busy.
// PARAMETERS
//  ADDR_BITS   12                 byte-address width; word address is ADDR_BITS-2 bits
//  DEPTH       1<<(ADDR_BITS-2)   number of 32-bit words (derived, localparam)
// PORTS
//  clk          in   1              system clock, rising edge
//  rst          in   1              asynchronous, active-low reset
//  addr         in   ADDR_BITS-2    word address (byte addr [ADDR_BITS-1:2])
//  data_in      in   32             store data, right-justified (byte in [7:0], half in [15:0])
//  sel          in   4              byte-lane select; bit i = byte [8i+7:8i]
//  rw           in   1              1 = write on this clock edge, 0 = read only
//  extend_type  in   1              read extension: 1 = sign-extend, 0 = zero-extend
//  data_out     out  32             read data, lanes shifted to bit 0 and extended
//  busy         out  1              1 while the clear sweep runs; CPU must stall
// BEHAVIOUR
//  - Read: combinational from mem[addr]; no clock latency; a write is visible after the edge that performs it.
//  - Read alignment by sel:
//    - 1111: whole word; extend_type ignored.
//    - 0011/1100: half at [15:0]/[31:16] -> data_out[15:0], extended from bit 15.
//    - 0001/0010/0100/1000: byte from its lane -> data_out[7:0], extended from bit 7.
//    - Any other pattern: mem[addr] & lane mask, no shift, no extension.
//    - sel=0000 reads 0.
//  - Write (rw=1, busy=0, rising clk): lanes selected by sel take the right-justified data_in shifted into place.
//    - Half to 1100 writes data_in[15:0] into [31:16].
//    - Byte to 0100 writes data_in[7:0] into [23:16].
//    - Other sel patterns write data_in lanes unshifted.
//    - Unselected lanes keep their value.
//  - rw=1 with sel=0000 changes nothing. Writes while busy=1 are dropped silently.
//  - addr wraps naturally; every value is legal. No out-of-range case exists.
//  - Clear FSM (DMEM_CLEAR_EN only). States CLEAR, READY; counter clr_ptr of ADDR_BITS-2 bits.
//    - rst low (async): state=CLEAR, clr_ptr=0, busy=1.
//    - CLEAR, each edge: mem[clr_ptr]<=0, clr_ptr++. At clr_ptr==DEPTH-1: write that word, go to READY.
//    - READY: busy=0 and stays there until the next reset.
//    - Sweep takes exactly DEPTH cycles after rst deasserts.
//    - rst asserted mid-sweep: restart from clr_ptr=0.
//    - data_out is forced to 0 while busy=1.
//  - Reset values: busy=1 (DMEM_CLEAR_EN) or 0 (without). data_out=0 while busy; otherwise it follows mem.
//  - Reset never alters mem contents except through the sweep.
// CONFIGURATION
//  DMEM_CLEAR_EN defined: clear FSM as above; every word reads 0 once busy falls.
//  DMEM_CLEAR_EN undefined:
//  - No FSM, no clr_ptr; busy tied 0.
//  - mem contents are never reset; reads and writes are legal from the first edge after rst deasserts.
// TESTING
//  1. [CLEAR_EN] Pulse rst low mid-run, release -> busy=1 for exactly 1024 cycles (ADDR_BITS=12), then 0; addr 0x3FF reads 0x00000000.
//  2. Write 0x12345678 sel=1111 addr=5, then read sel=0010 extend=0 -> 0x00000056. Read sel=1000 extend=1 -> 0x00000012.
//  3. Write 0x0000BEEF sel=1100 addr=7 over 0xFFFFFFFF -> word 0xBEEFFFFF. Read sel=1100 extend=1 -> 0xFFFFBEEF; extend=0 -> 0x0000BEEF.
//  4. Write byte 0x80 sel=0001 addr=2 -> read sel=0001 extend=1 -> 0xFFFFFF80. Upper lanes unchanged.
//  5. [CLEAR_EN] rw=1 addr=3 data 0xAAAAAAAA during sweep -> write dropped, word 3 reads 0 after busy falls.
//     Reassert rst at sweep cycle 500 -> full 1024-cycle sweep restarts.
//  6. rw=1 sel=0000 on a word holding 0xCAFEF00D -> word unchanged. Same-cycle read shows the old value; the new value appears after the edge.

Source files
------------

// File: rtl/data_mem.sv
// data_mem: word-organised data RAM for the MEM stage.
// Combinational lane-aligned, extended reads and synchronous byte-lane writes.
// Optional post-reset clear sweep (define DMEM_CLEAR_EN) holds the CPU off via busy.
module data_mem #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-3:0] addr,
    input  logic [31:0]          data_in,
    input  logic [3:0]           sel,
    input  logic                 rw,
    input  logic                 extend_type,
    output logic [31:0]          data_out,
    output logic                 busy
);

    localparam int AW    = ADDR_BITS - 2;
    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   lane_mask;
    logic [31:0]   wdata;
    logic [31:0]   rword;
    logic [31:0]   rdata;
    logic          wr_en;
    logic          clr_en;
    logic [AW-1:0] clr_addr;

`ifdef DMEM_CLEAR_EN
    typedef enum logic {
        CLEAR,
        READY
    } state_e;

    state_e        state_q;
    state_e        state_d;
    logic [AW-1:0] clr_ptr_q;
    logic [AW-1:0] clr_ptr_d;

    // Next-state for the clear sweep: walk every word once, then park in READY
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == CLEAR) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == {AW{1'b1}}) begin
                state_d = READY;
            end
        end
    end

    // Sweep state registers; reset restarts the sweep from word 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    assign busy     = (state_q == CLEAR);
    assign clr_en   = busy;
    assign clr_addr = clr_ptr_q;
`else
    assign busy     = 1'b0;
    assign clr_en   = 1'b0;
    assign clr_addr = '0;
`endif

    assign lane_mask = {{8{sel[3]}}, {8{sel[2]}},
                        {8{sel[1]}}, {8{sel[0]}}};
    assign wr_en     = rw & ~busy;
    assign rword     = mem[addr];

    // Shift right-justified store data into the lanes it targets
    always_comb begin
        case (sel)
            4'b1100: wdata = {data_in[15:0], 16'h0};
            4'b0010: wdata = {16'h0, data_in[7:0], 8'h0};
            4'b0100: wdata = {8'h0, data_in[7:0], 16'h0};
            4'b1000: wdata = {data_in[7:0], 24'h0};
            default: wdata = data_in;
        endcase
    end

    // Storage: sweep zeroes take priority, otherwise byte-lane writes
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Read path: align selected half/byte to bit 0 and extend
    always_comb begin
        case (sel)
            4'b1111: rdata = rword;
            4'b0011: rdata = {{16{extend_type & rword[15]}}, rword[15:0]};
            4'b1100: rdata = {{16{extend_type & rword[31]}}, rword[31:16]};
            4'b0001: rdata = {{24{extend_type & rword[7]}}, rword[7:0]};
            4'b0010: rdata = {{24{extend_type & rword[15]}}, rword[15:8]};
            4'b0100: rdata = {{24{extend_type & rword[23]}}, rword[23:16]};
            4'b1000: rdata = {{24{extend_type & rword[31]}}, rword[31:24]};
            default: rdata = rword & lane_mask;
        endcase
    end

    assign data_out = busy ? 32'h0 : rdata;

endmodule
